// File: rtl/reg_read_unit.sv
// Operand-read stage: two register-bank reads with write-first bypass, a busy
// scoreboard that stalls RAW hazards, and a single-entry valid/ready output slot.

module rru_src_sel #(parameter int N = 32) (
    input  logic [32*N-1:0] regs_flat,
    input  logic [31:0]     busy,
    input  logic            wb_load,
    input  logic [4:0]      wb_addr,
    input  logic [N-1:0]    wb_data,
    input  logic [4:0]      addr,
    output logic [N-1:0]    data,
    output logic            blocked
);
    logic wb_hit;

    assign wb_hit = wb_load && (wb_addr == addr);

    // The bank updates on this edge, so a write-back landing now must be forwarded.
    always_comb begin
        data = '0;
        if (addr != 5'd0)
            data = wb_hit ? wb_data : regs_flat[addr*N +: N];
    end

    assign blocked = (addr != 5'd0) && busy[addr] && !wb_hit;
endmodule

module reg_read_unit #(parameter int N = 32) (
    input  logic            clk,
    input  logic            rst,
    input  logic [32*N-1:0] regs_flat,
    input  logic            wb_load,
    input  logic [4:0]      wb_addr,
    input  logic [N-1:0]    wb_data,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    input  logic [4:0]      rd,
    input  logic            rd_en,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [N-1:0]    rs1_data,
    output logic [N-1:0]    rs2_data,
    output logic [31:0]     busy
);
    typedef enum logic {EMPTY, FULL} slot_t;

    slot_t             slot;
    logic [1:0][4:0]   src_addr;
    logic [1:0][N-1:0] src_data;
    logic [1:0]        src_blk;
    logic [31:0]       busy_r, busy_nxt;
    logic [N-1:0]      rs1_q, rs2_q;
    logic              hazard, accept;

    assign src_addr = {rs2, rs1};

    for (genvar i = 0; i < 2; i++) begin : g_src
        rru_src_sel #(.N(N)) u_sel (
            .regs_flat (regs_flat),
            .busy      (busy_r),
            .wb_load   (wb_load),
            .wb_addr   (wb_addr),
            .wb_data   (wb_data),
            .addr      (src_addr[i]),
            .data      (src_data[i]),
            .blocked   (src_blk[i])
        );
    end

    assign hazard    = |src_blk;
    assign rsp_valid = (slot == FULL);
    assign req_ready = !rst && (!rsp_valid || rsp_ready) && !hazard;
    assign accept    = req_valid && req_ready;
    assign rs1_data  = rs1_q;
    assign rs2_data  = rs2_q;
    assign busy      = busy_r;

    // Clear before set: a new writer to the address being written back stays pending.
    always_comb begin
        busy_nxt = busy_r;
        if (wb_load && wb_addr != 5'd0)
            busy_nxt[wb_addr] = 1'b0;
        if (accept && rd_en && rd != 5'd0)
            busy_nxt[rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot   <= EMPTY;
            busy_r <= '0;
            rs1_q  <= '0;
            rs2_q  <= '0;
        end else begin
            busy_r <= busy_nxt;
            case (slot)
                EMPTY: if (accept) slot <= FULL;
                FULL:  if (rsp_ready && !accept) slot <= EMPTY;
            endcase
            if (accept) begin
                rs1_q <= src_data[0];
                rs2_q <= src_data[1];
            end
        end
    end
endmodule

// File: tb/tb_reg_read_unit.sv
// Bench for reg_read_unit: directed scenarios plus randomized traffic checked
// against an array/flag model of the register file, scoreboard and output slot.

module tb_reg_read_unit;
    logic          clk = 0;
    logic          rst;
    logic [1023:0] regs_flat;
    logic          wb_load;
    logic [4:0]    wb_addr;
    logic [31:0]   wb_data;
    logic          req_valid, req_ready;
    logic [4:0]    rs1, rs2, rd;
    logic          rd_en;
    logic          rsp_valid, rsp_ready;
    logic [31:0]   rs1_data, rs2_data, busy;

    logic [31:0] regs [32];
    logic [31:0] m_busy;
    bit          m_full;
    logic [31:0] m_d1, m_d2;
    int          total = 0, bad = 0;

    reg_read_unit #(.N(32)) dut (
        .clk(clk), .rst(rst), .regs_flat(regs_flat), .wb_load(wb_load),
        .wb_addr(wb_addr), .wb_data(wb_data), .req_valid(req_valid),
        .req_ready(req_ready), .rs1(rs1), .rs2(rs2), .rd(rd), .rd_en(rd_en),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rs1_data(rs1_data),
        .rs2_data(rs2_data), .busy(busy)
    );

    always #5 clk = ~clk;

    always_comb begin
        regs_flat = '0;
        for (int i = 0; i < 32; i++) regs_flat[i*32 +: 32] = regs[i];
    end

    function automatic logic [31:0] m_val(input logic [4:0] s);
        if (s == 0) return 32'h0;
        if (wb_load && wb_addr == s) return wb_data;
        return regs[s];
    endfunction

    function automatic bit m_blk(input logic [4:0] s);
        return (s != 0) && m_busy[s] && !(wb_load && wb_addr == s);
    endfunction

    function automatic bit m_ready();
        return !rst && (!m_full || rsp_ready) && !(m_blk(rs1) || m_blk(rs2));
    endfunction

    function automatic void m_reset();
        m_busy = '0; m_full = 0; m_d1 = '0; m_d2 = '0;
    endfunction

    // Advance one clock; the model sees the inputs as they stood before the edge,
    // and the bank absorbs the write-back on the same edge.
    task automatic tick();
        bit          acc = req_valid && m_ready();
        logic [31:0] nb = m_busy;
        logic [31:0] n1 = m_d1, n2 = m_d2;
        bit          nf = m_full;
        if (acc) begin n1 = m_val(rs1); n2 = m_val(rs2); nf = 1; end
        else if (rsp_ready) nf = 0;
        if (wb_load && wb_addr != 0) nb[wb_addr] = 1'b0;
        if (acc && rd_en && rd != 0) nb[rd] = 1'b1;
        @(posedge clk); #1;
        if (rst) m_reset();
        else begin
            m_busy = nb; m_full = nf; m_d1 = n1; m_d2 = n2;
            if (wb_load && wb_addr != 0) regs[wb_addr] = wb_data;
        end
    endtask

    task automatic drive_req(input logic [4:0] a, input logic [4:0] b,
                             input logic [4:0] d, input logic de);
        req_valid = 1; rs1 = a; rs2 = b; rd = d; rd_en = de;
    endtask

    task automatic test_reset();
        rst = 1; wb_load = 0; wb_addr = 0; wb_data = 0; req_valid = 0;
        rs1 = 0; rs2 = 0; rd = 0; rd_en = 0; rsp_ready = 1;
        for (int i = 0; i < 32; i++) regs[i] = '0;
        m_reset();
        #3;
        total++; if (busy !== 32'h0) begin bad++; $display("FAIL reset_busy got=%h exp=0", busy); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        total++; if (rs1_data !== 32'h0 || rs2_data !== 32'h0) begin bad++; $display("FAIL reset_data got=%h/%h exp=0/0", rs1_data, rs2_data); end
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL reset_req_ready got=%b exp=0", req_ready); end
        tick();
        rst = 0; #1;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL post_reset_ready got=%b exp=1", req_ready); end
    endtask

    task automatic test_plain_read();
        regs[5] = 32'h11; regs[6] = 32'h22;
        drive_req(5, 6, 0, 0); rsp_ready = 1; #1;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL plain_ready got=%b exp=1", req_ready); end
        tick(); req_valid = 0;
        total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL plain_valid got=%b exp=1", rsp_valid); end
        total++; if (rs1_data !== 32'h11 || rs2_data !== 32'h22) begin bad++; $display("FAIL plain_data got=%h/%h exp=11/22", rs1_data, rs2_data); end
        total++; if (busy !== 32'h0) begin bad++; $display("FAIL plain_busy got=%h exp=0", busy); end
    endtask

    task automatic test_x0();
        regs[0] = 32'hFFFF_FFFF;
        drive_req(0, 0, 0, 0); tick();
        total++; if (rs1_data !== 32'h0 || rs2_data !== 32'h0) begin bad++; $display("FAIL x0_data got=%h/%h exp=0/0", rs1_data, rs2_data); end
        drive_req(0, 0, 0, 1); tick(); req_valid = 0;
        total++; if (busy !== 32'h0) begin bad++; $display("FAIL x0_busy got=%h exp=0", busy); end
    endtask

    task automatic test_raw_bypass();
        drive_req(0, 0, 7, 1); tick();
        total++; if (busy[7] !== 1'b1) begin bad++; $display("FAIL raw_set got=%b exp=1", busy[7]); end
        drive_req(7, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL raw_stall%0d got=%b exp=0", i, req_ready); end
            tick();
        end
        wb_load = 1; wb_addr = 7; wb_data = 32'hABCD; #1;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL raw_bypass_ready got=%b exp=1", req_ready); end
        tick(); req_valid = 0; wb_load = 0;
        total++; if (rs1_data !== 32'hABCD) begin bad++; $display("FAIL raw_bypass_data got=%h exp=abcd", rs1_data); end
        total++; if (busy[7] !== 1'b0) begin bad++; $display("FAIL raw_clear got=%b exp=0", busy[7]); end
    endtask

    task automatic test_backpressure();
        regs[1] = $urandom; regs[2] = $urandom;
        drive_req(5, 6, 0, 0); rsp_ready = 1; tick();
        rsp_ready = 0; drive_req(1, 2, 0, 0);
        for (int i = 0; i < 4; i++) begin
            #1;
            total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL bp_ready%0d got=%b exp=0", i, req_ready); end
            tick();
            total++; if (rsp_valid !== 1'b1 || rs1_data !== 32'h11 || rs2_data !== 32'h22) begin
                bad++; $display("FAIL bp_hold%0d got=%b/%h/%h exp=1/11/22", i, rsp_valid, rs1_data, rs2_data); end
        end
        rsp_ready = 1; #1;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b exp=1", req_ready); end
        tick(); req_valid = 0;
        total++; if (rsp_valid !== 1'b1 || rs1_data !== regs[1] || rs2_data !== regs[2]) begin
            bad++; $display("FAIL bp_swap got=%b/%h/%h exp=1/%h/%h", rsp_valid, rs1_data, rs2_data, regs[1], regs[2]); end
    endtask

    task automatic test_set_clear();
        drive_req(0, 0, 9, 1); tick();
        total++; if (busy[9] !== 1'b1) begin bad++; $display("FAIL sc_pre got=%b exp=1", busy[9]); end
        wb_load = 1; wb_addr = 9; wb_data = 32'h99; drive_req(0, 0, 9, 1); tick();
        req_valid = 0; wb_load = 0;
        total++; if (busy[9] !== 1'b1) begin bad++; $display("FAIL sc_set_wins got=%b exp=1", busy[9]); end
    endtask

    task automatic test_reset_mid();
        rsp_ready = 1;
        drive_req(0, 0, 3, 1); tick();
        drive_req(5, 6, 4, 1); tick();
        req_valid = 0; rsp_ready = 0; #1;
        total++; if (busy[4:3] !== 2'b11 || rsp_valid !== 1'b1) begin bad++; $display("FAIL rm_pre got=%b/%b exp=11/1", busy[4:3], rsp_valid); end
        #1 rst = 1; #1;
        total++; if (busy !== 32'h0 || rsp_valid !== 1'b0) begin bad++; $display("FAIL rm_state got=%h/%b exp=0/0", busy, rsp_valid); end
        total++; if (rs1_data !== 32'h0 || rs2_data !== 32'h0) begin bad++; $display("FAIL rm_data got=%h/%h exp=0/0", rs1_data, rs2_data); end
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL rm_ready got=%b exp=0", req_ready); end
        #1 rst = 0; m_reset();
        rsp_ready = 1; #1;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rm_recover got=%b exp=1", req_ready); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        for (int c = 0; c < 400; c++) begin
            req_valid = ($urandom_range(0, 3) != 0);
            rs1 = 5'($urandom_range(0, 7)); rs2 = 5'($urandom_range(0, 7));
            rd = 5'($urandom_range(0, 7)); rd_en = $urandom_range(0, 1) == 1;
            wb_load = ($urandom_range(0, 2) == 0);
            wb_addr = 5'($urandom_range(0, 7)); wb_data = $urandom;
            rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            total++; if (req_ready !== m_ready()) begin bad++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, req_ready, m_ready()); end
            tick();
            total++; if (rsp_valid !== m_full) begin bad++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, rsp_valid, m_full); end
            total++; if (rs1_data !== m_d1 || rs2_data !== m_d2) begin
                bad++; $display("FAIL rnd_data c=%0d got=%h/%h exp=%h/%h", c, rs1_data, rs2_data, m_d1, m_d2); end
            total++; if (busy !== m_busy) begin bad++; $display("FAIL rnd_busy c=%0d got=%h exp=%h", c, busy, m_busy); end
        end
        req_valid = 0; wb_load = 0;
    endtask

    initial begin
        test_reset();
        test_plain_read();
        test_x0();
        test_raw_bypass();
        test_backpressure();
        test_set_clear();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
